// File: rtl/tagged_stream_arbiter.sv
// +----------------------------------------------------------------------------+
// | tagged_stream_arbiter: packet-locked round-robin arbiter, N tagged inputs  |
// | to one output. Optional output register slice: TAGGED_ARBITER_OUT_REG_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tagged_stream_arbiter #(
  parameter int  NUM_STREAMS = 4,
  parameter type data_t      = logic [31:0],
  parameter int  TAG_WIDTH   = 4,
  parameter int  KEEP_WIDTH  = 4,
  parameter int  GRANT_W     = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  data_t                                 in_data [NUM_STREAMS],
  input  logic [NUM_STREAMS-1:0][TAG_WIDTH-1:0]  in_tag,
  input  logic [NUM_STREAMS-1:0][KEEP_WIDTH-1:0] in_keep,
  input  logic [NUM_STREAMS-1:0]                 in_last,
  input  logic [NUM_STREAMS-1:0]                 in_valid,
  output logic [NUM_STREAMS-1:0]                 in_ready,
  output data_t                                 out_data,
  output logic [TAG_WIDTH-1:0]                   out_tag,
  output logic [KEEP_WIDTH-1:0]                  out_keep,
  output logic                                  out_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [GRANT_W-1:0]                     grant_idx,
  output logic                                  busy
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    data_t                 data;
    logic [TAG_WIDTH-1:0]  tag;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } beat_t;

  localparam logic [GRANT_W-1:0] c_last_idx = GRANT_W'(NUM_STREAMS - 1);

  state_t             r_state;
  logic               r_busy;
  logic [GRANT_W-1:0] r_grant_idx;
  logic [GRANT_W-1:0] r_last_grant;

  logic               w_locked;
  logic               w_src_valid;
  logic               w_src_ready;
  logic               w_beat_fire;
  beat_t              w_sel_beat;
  logic [GRANT_W-1:0] w_next_grant;
  logic [GRANT_W-1:0] w_cand;
  logic               w_found;

  assign w_locked    = (r_state == S_LOCKED);
  assign w_src_valid = w_locked & in_valid[r_grant_idx];
  assign w_beat_fire = w_src_valid & w_src_ready;

  always_comb begin
    w_sel_beat.data = in_data[r_grant_idx];
    w_sel_beat.tag  = in_tag[r_grant_idx];
    w_sel_beat.keep = in_keep[r_grant_idx];
    w_sel_beat.last = in_last[r_grant_idx];
  end

  // Rotating priority: search upward from the input after the last winner.
  always_comb begin
    w_next_grant = r_last_grant;
    w_found      = 1'b0;
    w_cand       = '0;
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      w_cand = GRANT_W'((int'(r_last_grant) + k) % NUM_STREAMS);
      if (!w_found && in_valid[w_cand]) begin
        w_found      = 1'b1;
        w_next_grant = w_cand;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (w_locked && !rst) begin
      in_ready[r_grant_idx] = w_src_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_grant_idx  <= '0;
      r_last_grant <= c_last_idx;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|in_valid) begin
            r_state     <= S_LOCKED;
            r_busy      <= 1'b1;
            r_grant_idx <= w_next_grant;
          end
        end
        S_LOCKED: begin
          if (w_beat_fire && w_sel_beat.last) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_last_grant <= r_grant_idx;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_idx = r_grant_idx;
  assign busy      = r_busy;

`ifdef TAGGED_ARBITER_OUT_REG_EN
  // Two-entry skid slice: the skid entry absorbs the beat accepted while out stalls.
  beat_t r_out_beat;
  beat_t r_skid_beat;
  logic  r_out_valid;
  logic  r_skid_valid;

  assign w_src_ready = !r_skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (out_ready || !r_out_valid) begin
      if (r_skid_valid) begin
        r_out_beat   <= r_skid_beat;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_beat  <= w_sel_beat;
        r_out_valid <= w_src_valid;
      end
    end else if (w_src_valid && !r_skid_valid) begin
      r_skid_beat  <= w_sel_beat;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid = r_out_valid & !rst;
  assign out_data  = r_out_beat.data;
  assign out_tag   = r_out_beat.tag;
  assign out_keep  = r_out_beat.keep;
  assign out_last  = r_out_beat.last;
`else
  assign w_src_ready = out_ready;
  assign out_valid   = w_src_valid & !rst;
  assign out_data    = w_sel_beat.data;
  assign out_tag     = w_sel_beat.tag;
  assign out_keep    = w_sel_beat.keep;
  assign out_last    = w_sel_beat.last;
`endif

endmodule

`default_nettype wire

// File: doc/tagged_stream_arbiter.md
Name: tagged_stream_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one tagged stream output between NUM_STREAMS tagged input streams.
- Sits upstream of shared consumers, e.g. feeding a tagged duplicator or a single memory/compute lane from several producers.
- Once an input is granted, the grant is held until that input's beat with last=1 is accepted, so packets are never interleaved.
- Tag, keep, last and data pass through unchanged.

Parameters:
- NUM_STREAMS, default 4: number of input streams, ≥1.
- data_t, no default (taken from the interface): payload type.
- TAG_WIDTH, no default (taken from the interface): tag width in bits.
- GRANT_W, default $clog2(NUM_STREAMS) (1 when NUM_STREAMS=1): width of the grant index.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in[NUM_STREAMS]  tagged_i.s  data_t / TAG_WIDTH tag / keep / last / valid / ready  requester streams.
- out  tagged_i.m  same payload  arbitrated output stream.
- grant_idx  out  GRANT_W  index of the currently granted input; valid while busy=1.
- busy  out  1  high while a packet is locked onto the output.

Behaviour:
- Transfer occurs on a stream when valid && ready at a rising clk edge. Valid must not depend on ready; the arbiter never drops a beat.
- Two states, IDLE and LOCKED.
- State register reset values (applied when rst=1 at the edge):
  - state=IDLE, busy=0, grant_idx=0.
  - last_grant=NUM_STREAMS-1, so input 0 has first priority.
- Output values while rst is asserted and in IDLE: out.valid=0 and all in[i].ready=0.
- IDLE:
  - out.valid=0 and all in[i].ready=0.
  - If any in[i].valid=1, select the first valid index searching (last_grant+1) mod NUM_STREAMS upward with wrap-around.
  - Register it into grant_idx and go to LOCKED on the next cycle.
  - This gives one bubble cycle per packet: request-to-first-output latency is 1 cycle.
- LOCKED:
  - out.{data,tag,keep,last,valid} = in[grant_idx].{…}.
  - in[grant_idx].ready = out.ready; all other in[i].ready=0. Combinational passthrough, 0-cycle beat latency.
  - On an out transfer with out.last=1, go to IDLE and set last_grant<=grant_idx.
  - Otherwise stay LOCKED, including when in[grant_idx].valid drops mid-packet; the grant is held until last.
- Simultaneous requests: exactly one grant per arbitration. The rotating priority guarantees each continuously requesting input is granted within NUM_STREAMS packets.
- A requester that deasserts valid while in IDLE before being sampled is simply not considered. Valid only matters at the IDLE sampling edge.
- Single-beat packets (last=1 on the first beat) release the grant after 1 accepted beat.
- busy = (state==LOCKED).
- NUM_STREAMS=1: the arbiter always grants index 0; the IDLE bubble still applies.
- Reset mid-packet: state returns to IDLE immediately at the reset edge. The partial packet is abandoned; upstream must also be reset.
- No combinational path from out.ready to any in[i].valid, or from any in[i].valid to any in[i].ready.

Optional Feature:
- Macro: TAGGED_ARBITER_OUT_REG_EN.
- When defined:
  - A register slice (two-entry skid buffer) is inserted between the LOCKED mux and out.
  - out signals are registered, and in[grant_idx].ready comes from the skid buffer's not-full status, not from out.ready.
  - Beat latency becomes 1 cycle and full throughput is preserved.
  - The state machine moves to IDLE when the last beat enters the slice, so arbitration overlaps the drain.
  - out.valid=0 after reset.
- When undefined: combinational passthrough as described above, beat latency 0.

Test Plan:
- Reset, then in[2] sends a 3-beat packet with tag 0x5 and out.ready=1:
  - out is idle the cycle after valid rises, then shows 3 beats on consecutive cycles with tag 0x5 and last on the 3rd.
  - grant_idx=2 and busy=1 for exactly those 3 cycles.
- All 4 inputs continuously valid with 2-beat packets:
  - grant order is 0,1,2,3,0,… with one idle cycle between packets.
  - No beats are interleaved across inputs.
- in[1] packet of 4 beats with its valid dropped for 2 cycles after beat 2, while in[0] and in[3] request:
  - grant stays on 1 until the last beat is transferred.
  - in[0].ready and in[3].ready stay 0 throughout.
- out.ready toggling 1,0,1,0 during a 4-beat packet from in[3]:
  - in[3].ready mirrors out.ready each cycle.
  - Data beats arrive in order with no duplicates or losses.
- rst asserted for 1 cycle in the middle of in[0]'s packet while in[1] is valid:
  - next cycle state=IDLE, busy=0, out.valid=0.
  - After reset, in[1] is granted only once in[0] is no longer valid; with in[0] valid, input 0 wins (last_grant=NUM_STREAMS-1).
- With TAGGED_ARBITER_OUT_REG_EN, back-to-back 1-beat packets from in[0] and in[1] with out.ready=1:
  - out shows the beats with 1-cycle latency each and the data unchanged.
